ras_rx32: RTL

Receive-side halfword-to-word gearbox for the raspberry link. Accepts the 16-bit `rasin` stream, pairs consecutive halfwords into 32-bit words (low half first), and presents them on a 32-bit AXI-Stream-style output. The output feeds the 32-bit input stream of the network wrapper. The block frames a fixed number of words per `ap_start`. It is the receive counterpart of the 32→16 transmitter that drives `rasout`.

---
 rtl/ras_rx32.sv | 116 +++++++++++
 1 files changed

// File: rtl/ras_rx32.sv
// Receive-side gearbox for the raspberry link: pairs 16-bit halfwords (low first) into
// 32-bit stream words and frames FRAME_WORDS words per ap_start.
module ras_rx32 #(
  parameter int unsigned FRAME_WORDS = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  input  logic             rasin_valid,
  input  logic [15:0]      rasin_data,
  output logic             rasin_ready,
  output logic             output_r_TVALID,
  input  logic             output_r_TREADY,
  output logic [31:0]      output_r_TDATA,
  output logic             ap_done,
  output logic             ap_idle,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [CNT_W-1:0] FrameWordsC = CNT_W'(FRAME_WORDS);
  localparam logic [CNT_W-1:0] LastWordC   = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic [2:0] {StIdle, StLo, StHi, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      low_q, low_d;
  logic [31:0]      tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] asm_q, asm_d;
  logic             ready;
  logic             drain;

  always_comb begin
    state_d  = state_q;
    low_d    = low_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    ready    = 1'b0;
    drain    = tvalid_q & output_r_TREADY;

    if (drain) begin
      tvalid_d = 1'b0;
      if (cnt_q != FrameWordsC) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (ap_start) begin
          state_d = StLo;
          cnt_d   = '0;
          asm_d   = '0;
        end
      end
      StLo: begin
        ready = 1'b1;
        if (rasin_valid) begin
          low_d   = rasin_data;
          state_d = StHi;
        end
      end
      StHi: begin
        // Single-entry output register: a word being drained this cycle frees the slot.
        ready = ~tvalid_q | output_r_TREADY;
        if (rasin_valid && ready) begin
          tdata_d  = {rasin_data, low_q};
          tvalid_d = 1'b1;
          asm_d    = asm_q + 1'b1;
          state_d  = (asm_q == LastWordC) ? StDrain : StLo;
        end
      end
      StDrain: begin
        if (!tvalid_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ap_rst) begin
      state_q  <= StIdle;
      low_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      cnt_q    <= '0;
      asm_q    <= '0;
    end else begin
      state_q  <= state_d;
      low_q    <= low_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
    end
  end

  assign rasin_ready     = ready;
  assign output_r_TVALID = tvalid_q;
  assign output_r_TDATA  = tdata_q;
  assign word_count      = cnt_q;
  assign ap_done         = (state_q == StDone);
  assign ap_idle         = (state_q == StIdle);

endmodule
